// File: rtl/alu_ctrl_stage.sv
// Registered, handshaked ALU-control decode stage. It maps opcode/funct3/funct7 to an ALU op code,
// optionally decodes RV32M, holds M ops for a fixed latency, and supports stall and flush.
module alu_ctrl_stage #(
  parameter int unsigned ALUOP_W  = 5,
  parameter bit          ENABLE_M = 1'b1,
  parameter int unsigned MUL_LAT  = 3,
  parameter int unsigned DIV_LAT  = 33
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic [6:0]         funct7,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               is_muldiv,
  output logic               illegal
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  localparam logic [6:0] OPC_NOOP      = 7'b0000000;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
  localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MD   = 7'b0000001;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_AND    = 4'd2;
  localparam logic [3:0] ALU_OR     = 4'd3;
  localparam logic [3:0] ALU_XOR    = 4'd4;
  localparam logic [3:0] ALU_SLT    = 4'd5;
  localparam logic [3:0] ALU_SLL    = 4'd6;
  localparam logic [3:0] ALU_SLTU   = 4'd7;
  localparam logic [3:0] ALU_SRL    = 4'd8;
  localparam logic [3:0] ALU_SRA    = 4'd9;
  localparam logic [3:0] ALU_COPY_B = 4'd11;
  localparam logic [3:0] ALU_XXX    = 4'd15;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FULL} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ALUOP_W-1:0] alu_op_q, alu_op_d;
  logic               is_muldiv_q, is_muldiv_d;
  logic               illegal_q, illegal_d;

  logic [4:0] dec_op;
  logic       dec_md;
  logic       dec_ill;
  logic       accept;

  function automatic logic [3:0] base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  base_op = ALU_ADD;
      3'b001:  base_op = ALU_SLL;
      3'b010:  base_op = ALU_SLT;
      3'b011:  base_op = ALU_SLTU;
      3'b100:  base_op = ALU_XOR;
      3'b101:  base_op = ALU_SRL;
      3'b110:  base_op = ALU_OR;
      default: base_op = ALU_AND;
    endcase
  endfunction

  // Field decode; illegal encodings collapse to ALU_XXX
  always_comb begin
    dec_op  = {1'b0, ALU_XXX};
    dec_md  = 1'b0;
    dec_ill = 1'b0;
    case (opcode)
      OPC_LUI: dec_op = {1'b0, ALU_COPY_B};
      OPC_AUIPC, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_JAL, OPC_JALR:
        dec_op = {1'b0, ALU_ADD};
      OPC_NOOP: dec_op = {1'b0, ALU_XXX};
      OPC_ARI_RTYPE: begin
        if (funct7 == F7_BASE) begin
          dec_op = {1'b0, base_op(funct3)};
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          dec_op = {1'b0, ALU_SUB};
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          dec_op = {1'b0, ALU_SRA};
        end else if (funct7 == F7_MD && ENABLE_M) begin
          dec_op = {2'b10, funct3};
          dec_md = 1'b1;
        end else begin
          dec_ill = 1'b1;
        end
      end
      OPC_ARI_ITYPE: begin
        case (funct3)
          3'b001: begin
            if (funct7 == F7_BASE) dec_op = {1'b0, ALU_SLL};
            else dec_ill = 1'b1;
          end
          3'b101: begin
            if (funct7 == F7_BASE) dec_op = {1'b0, ALU_SRL};
            else if (funct7 == F7_ALT) dec_op = {1'b0, ALU_SRA};
            else dec_ill = 1'b1;
          end
          default: dec_op = {1'b0, base_op(funct3)};
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
  end

  assign in_ready = !flush && (state_q == S_IDLE || (state_q == S_FULL && out_ready));
  assign accept   = in_valid && in_ready;

  // Next state: consume/countdown first, then a new accept overrides, flush overrides all
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_op_d    = alu_op_q;
    is_muldiv_d = is_muldiv_q;
    illegal_d   = illegal_q;
    case (state_q)
      S_BUSY: begin
        if (cnt_q == '0) state_d = S_FULL;
        else cnt_d = cnt_q - CNT_W'(1);
      end
      S_FULL: if (out_ready) state_d = S_IDLE;
      default: ;
    endcase
    if (accept) begin
      alu_op_d    = ALUOP_W'(dec_op);
      is_muldiv_d = dec_md;
      illegal_d   = dec_ill;
      if (dec_md) begin
        state_d = S_BUSY;
        cnt_d   = funct3[2] ? DIV_LOAD : MUL_LOAD;
      end else begin
        state_d = S_FULL;
        cnt_d   = '0;
      end
    end
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      alu_op_q    <= ALUOP_W'(ALU_XXX);
      is_muldiv_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_op_q    <= alu_op_d;
      is_muldiv_q <= is_muldiv_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid = (state_q == S_FULL);
  assign alu_op    = alu_op_q;
  assign is_muldiv = is_muldiv_q;
  assign illegal   = illegal_q;

endmodule
